// File: rtl/uart_pkg.sv
// Shared defaults and read-side state encoding for the UART output buffer.
package uart_pkg;

  localparam int DEPTH_DEF  = 512;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SEND  = 2'd3
  } rd_state_t;

  // Little-endian byte lane select: lane 0 is bits [7:0].
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/output_ram.sv
// Simple dual-port word store: one write port, one registered read port.
module output_ram
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  // Contents are deliberately left unreset so the array maps onto block RAM.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/output_buf.sv
// Word FIFO feeding a byte serializer: the core writes 32-bit words, the
// UART transmitter receives them LSB byte first over a valid/ready handshake.
module output_buf
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic [31:0] wd,
  output logic        full,
  output logic        overflow,
  output logic        drained,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  rd_state_t         state;
  logic [1:0]        byte_idx;
  logic [31:0]       fetched;
  logic [31:0]       shift;
  logic [31:0]       rd_data;
  logic              push;
  logic              pop;
  logic              rd_en;

  assign full     = (count == (ADDR_W+1)'(DEPTH));
  assign drained  = (count == '0) && (state == ST_IDLE);
  assign push     = we && !full;
  assign pop      = (state == ST_LOAD);
  assign rd_en    = (state == ST_IDLE) && (count != '0);
  assign tx_valid = (state == ST_SEND);
  assign tx_data  = pick_byte(shift, byte_idx);

  // Gating with rstn keeps a write that coincides with reset out of the RAM.
  output_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push && rstn),
    .wr_addr (wr_ptr),
    .wr_data (wd),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= ST_IDLE;
      byte_idx <= '0;
      overflow <= 1'b0;
      fetched  <= '0;
      shift    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (we && full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      // The word leaves the FIFO (count drops) at LOAD, not when its last byte goes.
      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          fetched <= rd_data;
          state   <= ST_LOAD;
        end
        ST_LOAD: begin
          shift    <= fetched;
          byte_idx <= 2'd0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (byte_idx == 2'd3) begin
              state <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_buf.sv
// Directed/randomized bench for output_buf with a byte-queue reference model.
module tb_output_buf;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        we;
  logic [31:0] wd;
  logic        full;
  logic        overflow;
  logic        drained;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  output_buf dut (
    .clk      (clk),
    .rstn     (rstn),
    .we       (we),
    .wd       (wd),
    .full     (full),
    .overflow (overflow),
    .drained  (drained),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         n_bytes  = 0;
  logic [7:0] exp_q[$];
  bit         model_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  // One clock: model the edge from pre-edge inputs/outputs, then check at negedge.
  task automatic tick();
    logic pv, pr, pw, pf;
    logic [7:0]  pd;
    logic [31:0] pwd;
    pv = tx_valid; pr = tx_ready; pd = tx_data; pw = we; pf = full; pwd = wd;
    @(posedge clk);
    if (pw && !pf) push_word(pwd);
    if (pw && pf) model_ovf = 1'b1;
    if (pv && pr) begin
      n_bytes++;
      n_checks++;
      assert (exp_q.size() != 0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL extra_byte: observed %h expected no byte", pd);
      end
      if (exp_q.size() != 0) check("tx_byte", 32'(pd), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
    if (pv && !pr) begin
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'(pd));
    end
    check("overflow", 32'(overflow), 32'(model_ovf));
  endtask

  task automatic do_reset(input bit with_write);
    rstn = 1'b0; we = with_write; wd = 32'hDEADBEEF; tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1; we = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_drained", 32'(drained), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin tick(); n++; end
    check("valid_timeout", 32'(tx_valid), 32'd1);
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n = 0;
    we = 1'b0;
    while ((exp_q.size() != 0 || !drained) && n < budget) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < budget), 32'd1);
    check("drained", 32'(drained), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    int n;
    int bytes0;
    logic [ADDR_W_DEF-1:0] diff;

    rstn = 1'b0; we = 1'b0; wd = '0; tx_ready = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // Single word: latency to first tx_valid, then LSB-first byte order.
    tx_ready = 1'b1; we = 1'b1; wd = 32'h44332211;
    tick();
    we = 1'b0;
    check("lat_n0", 32'(tx_valid), 32'd0);
    tick();
    check("lat_n1", 32'(tx_valid), 32'd0);
    tick();
    check("lat_n2", 32'(tx_valid), 32'd0);
    tick();
    check("lat_n3", 32'(tx_valid), 32'd1);
    check("first_byte", 32'(tx_data), 32'h11);
    drain(1'b0, 50);

    // Fill: one word parked in the serializer, then 512 more fill the FIFO.
    do_reset(1'b0);
    tx_ready = 1'b0; we = 1'b1; wd = $urandom;
    tick();
    we = 1'b0;
    wait_valid(10);
    bytes0 = n_bytes;
    for (int i = 0; i < 512; i++) begin
      check("full_early", 32'(full), 32'd0);
      we = 1'b1; wd = $urandom;
      tick();
    end
    we = 1'b0;
    check("full_set", 32'(full), 32'd1);
    check("ovf_before", 32'(overflow), 32'd0);
    we = 1'b1; wd = 32'hBAD0BAD0;
    tick();
    we = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("full_hold", 32'(full), 32'd1);
    drain(1'b0, 6000);
    check("fill_bytes", 32'(n_bytes - bytes0), 32'd2052);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("full_clear", 32'(full), 32'd0);

    // Random backpressure with random writes.
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); wd = $urandom;
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain(1'b1, 3000);

    // Write coinciding with LOAD while five words are queued.
    do_reset(1'b0);
    tx_ready = 1'b0; we = 1'b1; wd = $urandom;
    tick();
    we = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; wd = $urandom;
      tick();
    end
    we = 1'b0;
    check("count_five", 32'(dut.count), 32'd5);
    tx_ready = 1'b1;
    n = 0;
    while (dut.state != ST_LOAD && n < 20) begin tick(); n++; end
    check("load_reached", 32'(dut.state == ST_LOAD), 32'd1);
    check("count_pre_load", 32'(dut.count), 32'd5);
    we = 1'b1; wd = $urandom;
    tick();
    we = 1'b0;
    check("count_post_load", 32'(dut.count), 32'd5);
    diff = dut.wr_ptr - dut.rd_ptr;
    check("ptr_gap", 32'(diff), 32'd5);
    drain(1'b1, 1000);

    // Wrap-around: 600 words written while the serializer keeps draining.
    do_reset(1'b0);
    acc = 0; n = 0;
    while (acc < 600 && n < 20000) begin
      tx_ready = 1'b1;
      we = !full && ($urandom_range(0, 3) == 0);
      wd = $urandom;
      if (we) acc++;
      tick();
      n++;
    end
    we = 1'b0;
    check("wrap_timeout", 32'(acc), 32'd600);
    check("wr_ptr_wrap", 32'(dut.wr_ptr), 32'd88);
    drain(1'b0, 6000);
    check("rd_ptr_wrap", 32'(dut.rd_ptr), 32'd88);
    check("wrap_ovf", 32'(overflow), 32'd0);

    // Reset in the middle of a word, with a write on the reset edge.
    do_reset(1'b0);
    tx_ready = 1'b0; we = 1'b1; wd = 32'h5A6B7C8D;
    tick();
    we = 1'b0;
    wait_valid(10);
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    check("mid_byte_idx", 32'(dut.byte_idx), 32'd2);
    check("mid_byte", 32'(tx_data), 32'h6B);
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_drained", 32'(drained), 32'd1);
    check("post_rst_valid", 32'(tx_valid), 32'd0);
    we = 1'b1; wd = 32'hA5A5A5A5;
    tick();
    we = 1'b0;
    bytes0 = n_bytes;
    drain(1'b1, 200);
    check("a5_bytes", 32'(n_bytes - bytes0), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
